// File: rtl/id_decode_queue.sv
// Instruction queue between fetch and decode with combinational R/I/J decode of the head entry.
// Optional build macro ID_PERF_CNT_EN adds saturating per-type pop counters.
module id_decode_queue #(
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int DELAY_SLOT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_addr,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_addr,
    output logic [2:0]                 out_type,
    output logic [5:0]                 out_opcode,
    output logic [5:0]                 out_funct,
    output logic [4:0]                 out_shamt,
    output logic                       out_rd_en_1,
    output logic                       out_rd_en_2,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic                       out_wr_en,
    output logic [4:0]                 out_wr_addr,
    output logic [31:0]                out_imm,
    output logic [31:0]                out_jtarget,
    output logic [31:0]                out_link,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_WIDTH-1:0]       perf_r_cnt,
    output logic [CNT_WIDTH-1:0]       perf_i_cnt,
    output logic [CNT_WIDTH-1:0]       perf_j_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [31:0] LINK_OFS = (DELAY_SLOT != 0) ? 32'd8 : 32'd4;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'b000,
        TYPE_R    = 3'b100,
        TYPE_I    = 3'b010,
        TYPE_J    = 3'b001
    } itype_e;

    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;
    logic [31:0]      head_addr, head_inst, pc4;
    logic [5:0]       opcode;
    itype_e           head_type;

    assign in_ready  = (occupancy != OCC_W'(DEPTH));
    assign out_valid = (occupancy != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: storage carries no reset; occupancy alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];
    assign opcode    = head_inst[31:26];
    assign pc4       = head_addr + 32'd4;
    assign out_type  = head_type;
    assign out_addr  = out_valid ? head_addr : '0;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        head_type   = TYPE_NONE;
        out_opcode  = '0;
        out_funct   = '0;
        out_shamt   = '0;
        out_rd_en_1 = 1'b0;
        out_rd_en_2 = 1'b0;
        out_rs      = '0;
        out_rt      = '0;
        out_wr_en   = 1'b0;
        out_wr_addr = '0;
        out_imm     = '0;
        out_jtarget = '0;
        out_link    = '0;
        if (out_valid) begin
            out_opcode = opcode;
            if (opcode == OP_SPECIAL) begin
                head_type   = TYPE_R;
                out_funct   = head_inst[5:0];
                out_shamt   = head_inst[10:6];
                out_rd_en_1 = 1'b1;
                out_rd_en_2 = 1'b1;
                out_rs      = head_inst[25:21];
                out_rt      = head_inst[20:16];
                if (head_inst[5:0] != FN_JR) begin
                    out_wr_en   = 1'b1;
                    out_wr_addr = head_inst[15:11];
                end
            end else if (opcode == OP_J || opcode == OP_JAL) begin
                head_type   = TYPE_J;
                out_jtarget = (pc4 & 32'hF000_0000) | {4'b0, head_inst[25:0], 2'b00};
                if (opcode == OP_JAL) begin
                    out_wr_en   = 1'b1;
                    out_wr_addr = 5'd31;
                    out_link    = head_addr + LINK_OFS;
                end
            end else begin
                head_type   = TYPE_I;
                out_rd_en_1 = 1'b1;
                out_rs      = head_inst[25:21];
                // Branches and stores also consume rt as a source.
                if (opcode inside {6'h04, 6'h05, [6'h28:6'h2B]}) begin
                    out_rd_en_2 = 1'b1;
                    out_rt      = head_inst[20:16];
                end
                if (opcode inside {[6'h08:6'h0F], [6'h20:6'h25]}) begin
                    out_wr_en   = 1'b1;
                    out_wr_addr = head_inst[20:16];
                end
                if (opcode inside {[6'h0C:6'h0F]})
                    out_imm = {16'h0000, head_inst[15:0]};
                else
                    out_imm = {{16{head_inst[15]}}, head_inst[15:0]};
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    // A pop in a flush cycle is discarded, so it is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_r_cnt <= '0;
            perf_i_cnt <= '0;
            perf_j_cnt <= '0;
        end else if (pop && !flush) begin
            if (head_type == TYPE_R && perf_r_cnt != '1) perf_r_cnt <= perf_r_cnt + 1'b1;
            if (head_type == TYPE_I && perf_i_cnt != '1) perf_i_cnt <= perf_i_cnt + 1'b1;
            if (head_type == TYPE_J && perf_j_cnt != '1) perf_j_cnt <= perf_j_cnt + 1'b1;
        end
    end
`else
    assign perf_r_cnt = '0;
    assign perf_i_cnt = '0;
    assign perf_j_cnt = '0;
`endif

endmodule

// File: tb/tb_id_decode_queue.sv
// Self-checking bench for id_decode_queue: decode vector table, queue corner sequences, random run against a queue model.
module tb_id_decode_queue;

    localparam int DEPTH      = 4;
    localparam int CNT_W      = 32;
    localparam int DELAY_SLOT = 1;
`ifdef ID_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  typ;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic        rd1;
        logic        rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [31:0] link;
    } dec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        dec_t        exp;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_addr, in_inst, out_addr, out_imm, out_jtarget, out_link;
    logic [2:0]  out_type;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_shamt, out_rs, out_rt, out_wr_addr;
    logic        out_rd_en_1, out_rd_en_2, out_wr_en;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0] perf_r_cnt, perf_i_cnt, perf_j_cnt;

    int tests = 0;
    int fails = 0;

    entry_t           q[$];
    logic [CNT_W-1:0] m_r, m_i, m_j;

    always #5 clk = ~clk;

    id_decode_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_W), .DELAY_SLOT(DELAY_SLOT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_type(out_type), .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt),
        .out_rd_en_1(out_rd_en_1), .out_rd_en_2(out_rd_en_2), .out_rs(out_rs), .out_rt(out_rt),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_imm(out_imm),
        .out_jtarget(out_jtarget), .out_link(out_link), .occupancy(occupancy),
        .perf_r_cnt(perf_r_cnt), .perf_i_cnt(perf_i_cnt), .perf_j_cnt(perf_j_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the instruction-class rules.
    function automatic dec_t model_decode(input logic [31:0] pc, input logic [31:0] w);
        dec_t d;
        logic [5:0] op;
        d = '{default: '0};
        op = w[31:26];
        d.opcode = op;
        if (op == 6'd0) begin
            d.typ = 3'b100;
            d.rd1 = 1'b1; d.rd2 = 1'b1;
            d.rs = w[25:21]; d.rt = w[20:16];
            d.funct = w[5:0]; d.shamt = w[10:6];
            if (w[5:0] != 6'h08) begin d.wr_en = 1'b1; d.wr_addr = w[15:11]; end
        end else if (op == 6'd2 || op == 6'd3) begin
            d.typ = 3'b001;
            d.jt = ((pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
            if (op == 6'd3) begin
                d.wr_en = 1'b1; d.wr_addr = 5'd31;
                d.link = pc + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);
            end
        end else begin
            d.typ = 3'b010;
            d.rd1 = 1'b1; d.rs = w[25:21];
            if (op == 6'h04 || op == 6'h05 || (op >= 6'h28 && op <= 6'h2B)) begin
                d.rd2 = 1'b1; d.rt = w[20:16];
            end
            if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h25)) begin
                d.wr_en = 1'b1; d.wr_addr = w[20:16];
            end
            if (op >= 6'h0C && op <= 6'h0F) d.imm = w & 32'h0000_FFFF;
            else                             d.imm = 32'(signed'(w[15:0]));
        end
        return d;
    endfunction

    task automatic check_dec(input string p, input dec_t e);
        check({p, " type"},    out_type,    e.typ);
        check({p, " opcode"},  out_opcode,  e.opcode);
        check({p, " funct"},   out_funct,   e.funct);
        check({p, " shamt"},   out_shamt,   e.shamt);
        check({p, " rd_en_1"}, out_rd_en_1, e.rd1);
        check({p, " rd_en_2"}, out_rd_en_2, e.rd2);
        check({p, " rs"},      out_rs,      e.rs);
        check({p, " rt"},      out_rt,      e.rt);
        check({p, " wr_en"},   out_wr_en,   e.wr_en);
        check({p, " wr_addr"}, out_wr_addr, e.wr_addr);
        check({p, " imm"},     out_imm,     e.imm);
        check({p, " jtarget"}, out_jtarget, e.jt);
        check({p, " link"},    out_link,    e.link);
    endtask

    task automatic compare_all();
        dec_t e;
        e = '{default: '0};
        if (q.size() != 0) e = model_decode(q[0].addr, q[0].inst);
        check("out_valid", out_valid, 32'(q.size() != 0));
        check("in_ready",  in_ready,  32'(q.size() != DEPTH));
        check("occupancy", occupancy, 32'(q.size()));
        check("out_addr",  out_addr,  (q.size() != 0) ? q[0].addr : 32'h0);
        check_dec("model", e);
        check("perf_r", perf_r_cnt, PERF_EN ? m_r : '0);
        check("perf_i", perf_i_cnt, PERF_EN ? m_i : '0);
        check("perf_j", perf_j_cnt, PERF_EN ? m_j : '0);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] w,
                        input logic rdy, input logic fl, input logic r);
        bit     do_push, do_pop;
        entry_t hd;
        dec_t   hdec;
        in_valid = v; in_addr = a; in_inst = w; out_ready = rdy; flush = fl; rst = r;
        do_push = v && (q.size() < DEPTH);
        do_pop  = rdy && (q.size() > 0);
        hd = '{addr: 32'h0, inst: 32'h0};
        if (q.size() != 0) hd = q[0];
        @(posedge clk);
        #1;
        if (r) begin
            q.delete(); m_r = '0; m_i = '0; m_j = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (do_pop) begin
                hdec = model_decode(hd.addr, hd.inst);
                if (hdec.typ == 3'b100 && m_r != '1) m_r++;
                if (hdec.typ == 3'b010 && m_i != '1) m_i++;
                if (hdec.typ == 3'b001 && m_j != '1) m_j++;
                void'(q.pop_front());
            end
            if (do_push) q.push_back('{addr: a, inst: w});
        end
        compare_all();
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w, input logic [2:0] typ,
                                input logic rd1, input logic rd2, input logic [4:0] rs, input logic [4:0] rt,
                                input logic we, input logic [4:0] wa, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [31:0] imm, input logic [31:0] jt, input logic [31:0] link);
        vec_t v;
        v.addr = a; v.inst = w;
        v.exp = '{typ: typ, opcode: w[31:26], funct: fn, shamt: sh, rd1: rd1, rd2: rd2, rs: rs, rt: rt,
                  wr_en: we, wr_addr: wa, imm: imm, jt: jt, link: link};
        return v;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [5:0]  ops [12];
        ops = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0F, 6'h20, 6'h23, 6'h25, 6'h28, 6'h2B};
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[31:26] = 6'h00;
            1: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
            2: w[31:26] = 6'h02;
            3: w[31:26] = 6'h03;
            4, 5: w[31:26] = ops[$urandom_range(0, 11)];
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        vec_t        tbl [14];
        logic [31:0] a;
        tbl[0]  = mk(32'h0000_0000, 32'h012A_4020, 3'b100, 1, 1,  9, 10, 1,  8, 6'h20, 0, 32'h0, 32'h0, 32'h0);
        tbl[1]  = mk(32'h0000_0004, 32'h2508_FFFF, 3'b010, 1, 0,  8,  0, 1,  8, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        tbl[2]  = mk(32'h0000_0008, 32'h3508_FFFF, 3'b010, 1, 0,  8,  0, 1,  8, 0, 0, 32'h0000_FFFF, 32'h0, 32'h0);
        tbl[3]  = mk(32'h0040_0010, 32'h0C10_0000, 3'b001, 0, 0,  0,  0, 1, 31, 0, 0, 32'h0, 32'h0040_0000, 32'h0040_0018);
        tbl[4]  = mk(32'h0000_0020, 32'h03E0_0008, 3'b100, 1, 1, 31,  0, 0,  0, 6'h08, 0, 32'h0, 32'h0, 32'h0);
        tbl[5]  = mk(32'h0000_0024, 32'h1022_FFFF, 3'b010, 1, 1,  1,  2, 0,  0, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        tbl[6]  = mk(32'h0000_0028, 32'hACC5_0004, 3'b010, 1, 1,  6,  5, 0,  0, 0, 0, 32'h0000_0004, 32'h0, 32'h0);
        tbl[7]  = mk(32'h0000_002C, 32'h8CC5_FFF8, 3'b010, 1, 0,  6,  0, 1,  5, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h0);
        tbl[8]  = mk(32'hF000_0000, 32'h0800_0001, 3'b001, 0, 0,  0,  0, 0,  0, 0, 0, 32'h0, 32'hF000_0004, 32'h0);
        tbl[9]  = mk(32'h0000_0030, 32'h0003_1100, 3'b100, 1, 1,  0,  3, 1,  2, 6'h00, 4, 32'h0, 32'h0, 32'h0);
        tbl[10] = mk(32'h0000_0034, 32'h3C01_ABCD, 3'b010, 1, 0,  0,  0, 1,  1, 0, 0, 32'h0000_ABCD, 32'h0, 32'h0);
        tbl[11] = mk(32'hFFFF_FFF8, 32'h0C00_0000, 3'b001, 0, 0,  0,  0, 1, 31, 0, 0, 32'h0, 32'hF000_0000, 32'h0000_0000);
        tbl[12] = mk(32'h0000_0038, 32'h28A3_8000, 3'b010, 1, 0,  5,  0, 1,  3, 0, 0, 32'hFFFF_8000, 32'h0, 32'h0);
        tbl[13] = mk(32'h0000_003C, 32'hFC00_0000, 3'b010, 1, 0,  0,  0, 0,  0, 0, 0, 32'h0, 32'h0, 32'h0);

        m_r = '0; m_i = '0; m_j = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_addr = '0; in_inst = '0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("reset in_ready", in_ready, 1);
        check("reset out_type", out_type, 0);

        // Decode table: each vector pushed alone, checked at the head, then popped.
        foreach (tbl[k]) begin
            step(1, tbl[k].addr, tbl[k].inst, 0, 0, 0);
            check_dec($sformatf("vec%0d", k), tbl[k].exp);
            step(0, 0, 0, 1, 0, 0);
        end

        // Fill to DEPTH from a non-zero pointer, 5th push ignored, drain in order.
        for (int k = 0; k < DEPTH; k++) step(1, 32'h100 + 32'(4 * k), rand_inst(), 0, 0, 0);
        check("full occupancy", occupancy, DEPTH);
        check("full in_ready", in_ready, 0);
        step(1, 32'h110, rand_inst(), 0, 0, 0);
        check("ignored push occupancy", occupancy, DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("order %0d", k), out_addr, 32'h100 + 32'(4 * k));
            step(0, 0, 0, 1, 0, 0);
        end
        check("drained out_valid", out_valid, 0);

        // Simultaneous push and pop keeps occupancy.
        step(1, 32'h200, rand_inst(), 0, 0, 0);
        step(1, 32'h204, rand_inst(), 0, 0, 0);
        step(1, 32'h208, rand_inst(), 1, 0, 0);
        check("push+pop occupancy", occupancy, 2);
        check("push+pop head", out_addr, 32'h204);
        step(1, 32'h20C, rand_inst(), 0, 0, 0);

        // Flush with push and pop requested at occupancy 3.
        step(1, 32'h300, 32'h012A_4020, 1, 1, 0);
        check("flush occupancy", occupancy, 0);
        check("flush out_valid", out_valid, 0);
        check("flush out_type", out_type, 0);
        check("flush out_addr", out_addr, 0);
        step(0, 0, 0, 1, 0, 0);
        check("flush dropped push", occupancy, 0);

        // Per-type pop counters across a flush, then reset.
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h400, 32'h012A_4020, 0, 0, 0);
        step(1, 32'h404, 32'h03E0_0008, 0, 0, 0);
        step(1, 32'h408, 32'h2508_FFFF, 0, 0, 0);
        step(1, 32'h40C, 32'h0800_0001, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 0);
        step(1, 32'h410, 32'h3508_FFFF, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 32'h414, 32'h0003_1100, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("perf r", perf_r_cnt, PERF_EN ? 32'd3 : 32'd0);
        check("perf i", perf_i_cnt, PERF_EN ? 32'd1 : 32'd0);
        check("perf j", perf_j_cnt, PERF_EN ? 32'd1 : 32'd0);
        step(0, 0, 0, 0, 0, 1);
        check("perf r after rst", perf_r_cnt, 0);

        // Reset mid-stream discards queued entries, and overrides a flush.
        step(1, 32'h500, rand_inst(), 0, 0, 0);
        step(1, 32'h504, rand_inst(), 0, 0, 0);
        step(1, 32'h508, rand_inst(), 1, 1, 1);
        check("rst mid-stream occupancy", occupancy, 0);

        // Random traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                            : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 99) < 60, a, rand_inst(), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
